// File: rtl/mnist_pkg.sv
// Shared constants and loader state encodings for the MNIST inference path.
// Used by the image loader, the control FSM and the testbench.
package mnist_pkg;

    localparam int         N_PIX     = 784;
    localparam int         PIX_W     = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         TO_CYCLES = 100000;
    localparam int         ADDR_W    = 10;

    typedef enum logic [2:0] {
        LD_HUNT    = 3'd0,
        LD_RECV    = 3'd1,
        LD_CHK     = 3'd2,
        LD_ARM     = 3'd3,
        LD_RELEASE = 3'd4
    } loader_state_t;

    // Running modulo-256 sum used for the optional frame checksum.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/img_buf.sv
// Pixel frame store: simple dual-port RAM, one write port and one registered
// read port, coded so synthesis maps it onto block RAM.
module img_buf #(
    parameter int N_PIX  = 784,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [PIX_W-1:0]  o_rd_data
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(N_PIX);

    logic [PIX_W-1:0] r_mem [N_PIX];
    logic [PIX_W-1:0] r_rd_data;
    logic             w_rd_in_range;

    assign w_rd_in_range = (i_rd_addr < LIMIT);

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-address read during a write returns the previous contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/img_loader.sv
// UART frame loader: hunts for the sync byte, stores N_PIX pixels, then requests
// one inference. Define IMG_LOADER_CHKSUM_EN to require a trailing checksum byte.
module img_loader #(
    parameter int         N_PIX     = mnist_pkg::N_PIX,
    parameter int         PIX_W     = mnist_pkg::PIX_W,
    parameter logic [7:0] SYNC_BYTE = mnist_pkg::SYNC_BYTE,
    parameter int         TO_CYCLES = mnist_pkg::TO_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic [9:0]       rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic             start,
    input  logic             done,
    output logic             ready,
    output logic             overrun,
    output logic             frame_err
);

    import mnist_pkg::*;

    localparam int                ADDR_W   = 10;
    localparam int                TO_W     = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYCLES - 1);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [ADDR_W-1:0] r_wptr;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_overrun;
    logic              r_frame_err;

    logic              w_sync;
    logic              w_wr_en;
    logic              w_err;
    logic              w_drop;
    logic              w_timing;
    logic              w_to_expired;

`ifdef IMG_LOADER_CHKSUM_EN
    logic [7:0]        r_sum;
`endif

    assign w_timing     = (r_state == LD_RECV) || (r_state == LD_CHK);
    assign w_to_expired = (r_to_cnt == TO_LAST);
    assign w_drop       = rx_valid && ((r_state == LD_ARM) || (r_state == LD_RELEASE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LD_HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    // A byte in the expiry cycle wins over the timeout.
    always_comb begin
        w_next  = r_state;
        w_sync  = 1'b0;
        w_wr_en = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            LD_HUNT: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_sync = 1'b1;
                    w_next = LD_RECV;
                end
            end
            LD_RECV: begin
                if (rx_valid) begin
                    w_wr_en = 1'b1;
                    if (r_wptr == LAST_PIX) begin
`ifdef IMG_LOADER_CHKSUM_EN
                        w_next = LD_CHK;
`else
                        w_next = LD_ARM;
`endif
                    end
                end else if (w_to_expired) begin
                    w_err  = 1'b1;
                    w_next = LD_HUNT;
                end
            end
`ifdef IMG_LOADER_CHKSUM_EN
            LD_CHK: begin
                if (rx_valid) begin
                    if (rx_data == r_sum) begin
                        w_next = LD_ARM;
                    end else begin
                        w_err  = 1'b1;
                        w_next = LD_HUNT;
                    end
                end else if (w_to_expired) begin
                    w_err  = 1'b1;
                    w_next = LD_HUNT;
                end
            end
`endif
            LD_ARM: begin
                if (done) begin
                    w_next = LD_RELEASE;
                end
            end
            LD_RELEASE: begin
                if (!done) begin
                    w_next = LD_HUNT;
                end
            end
            default: begin
                w_next = LD_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_to_cnt    <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (w_sync) begin
                r_wptr <= '0;
            end else if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_sync) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (!w_timing || rx_valid) begin
                r_to_cnt <= '0;
            end else if (!w_to_expired) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

`ifdef IMG_LOADER_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_sync) begin
            r_sum <= '0;
        end else if (w_wr_en) begin
            r_sum <= chk_add(r_sum, rx_data);
        end
    end
`endif

    img_buf #(
        .N_PIX  (N_PIX),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_img_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wptr),
        .i_wr_data (rx_data[PIX_W-1:0]),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign start     = (r_state == LD_ARM);
    assign ready     = (r_state == LD_HUNT);
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_img_loader.sv
// Directed self-checking bench for img_loader, run with a short inter-byte
// timeout; checksum scenarios are added when IMG_LOADER_CHKSUM_EN is defined.
module tb_img_loader;

    import mnist_pkg::*;

    localparam int TB_TO = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [9:0] rd_addr = 10'd0;
    logic [7:0] rd_data;
    logic       start;
    logic       done = 1'b0;
    logic       ready;
    logic       overrun;
    logic       frame_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] chk_sum;

    always #5 clk = ~clk;

    img_loader #(
        .TO_CYCLES (TB_TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .start     (start),
        .done      (done),
        .ready     (ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] pix(input int sel, input int i);
        if (sel == 0) return 8'(i % 256);
        return 8'((3 * i + 7) % 256);
    endfunction

    task automatic send_pixels(input int sel, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            chk_sum = chk_sum + pix(sel, i);
            send_byte(pix(sel, i));
        end
    endtask

    task automatic read_pix(input logic [9:0] a);
        rd_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b want 1", ready); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL rst_start got %b want 0", start); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_rd_data got %0h want 0", rd_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_overrun got %b want 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_err got %b want 0", frame_err); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_clean_frame;
        chk_sum = 8'h00;
        send_byte(SYNC_BYTE);
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL clean_ready_recv got %b want 0", ready); end
        send_pixels(0, 0, N_PIX - 1);
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL clean_start_early got %b want 0", start); end
        send_pixels(0, N_PIX - 1, 1);
`ifdef IMG_LOADER_CHKSUM_EN
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL clean_start_before_chk got %b want 0", start); end
        checks++; if (chk_sum !== 8'hF8) begin errors++; $display("[TB] FAIL clean_bench_sum got %0h want f8", chk_sum); end
        send_byte(8'hF8);
`endif
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL clean_start got %b want 1", start); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL clean_ready_arm got %b want 0", ready); end
        read_pix(10'd300);
        checks++; if (rd_data !== 8'd44) begin errors++; $display("[TB] FAIL read_300 got %0d want 44", rd_data); end
        read_pix(10'd783);
        checks++; if (rd_data !== 8'd15) begin errors++; $display("[TB] FAIL read_783 got %0d want 15", rd_data); end
        read_pix(10'd255);
        checks++; if (rd_data !== 8'd255) begin errors++; $display("[TB] FAIL read_255 got %0d want 255", rd_data); end
        read_pix(10'd784);
        checks++; if (rd_data !== 8'd0) begin errors++; $display("[TB] FAIL read_784 got %0d want 0", rd_data); end
        read_pix(10'd1023);
        checks++; if (rd_data !== 8'd0) begin errors++; $display("[TB] FAIL read_1023 got %0d want 0", rd_data); end
    endtask

    task automatic test_overrun;
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_before got %b want 0", overrun); end
        for (int i = 0; i < 5; i++) send_byte(8'h3C);
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set got %b want 1", overrun); end
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL ovr_start_held got %b want 1", start); end
        read_pix(10'd0);
        checks++; if (rd_data !== 8'd0) begin errors++; $display("[TB] FAIL ovr_buf0 got %0h want 0", rd_data); end
        read_pix(10'd4);
        checks++; if (rd_data !== 8'd4) begin errors++; $display("[TB] FAIL ovr_buf4 got %0h want 4", rd_data); end
    endtask

    task automatic test_handshake;
        done = 1'b1;
        idle(1);
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL hs_start_fall got %b want 0", start); end
        idle(2);
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL hs_ready_release got %b want 0", ready); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL hs_start_release got %b want 0", start); end
        done = 1'b0;
        idle(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL hs_ready got %b want 1", ready); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL hs_overrun_sticky got %b want 1", overrun); end
    endtask

    task automatic test_timeout;
        int pulses;
        int first_k;
        int start_seen;
        pulses     = 0;
        first_k    = -1;
        start_seen = 0;
        send_byte(SYNC_BYTE);
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear got %b want 0", overrun); end
        for (int i = 0; i < 10; i++) send_byte(8'h50 + 8'(i));
        for (int k = 1; k <= TB_TO + 5; k++) begin
            idle(1);
            if (frame_err === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
            if (start === 1'b1) start_seen++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL to_pulse_count got %0d want 1", pulses); end
        checks++; if (first_k !== TB_TO) begin errors++; $display("[TB] FAIL to_pulse_cycle got %0d want %0d", first_k, TB_TO); end
        checks++; if (start_seen !== 0) begin errors++; $display("[TB] FAIL to_start got %0d want 0", start_seen); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL to_ready got %b want 1", ready); end
    endtask

    task automatic test_timeout_collision;
        send_byte(SYNC_BYTE);
        send_byte(8'h11);
        idle(TB_TO - 1);
        send_byte(8'h77);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL coll_err got %b want 0", frame_err); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL coll_ready got %b want 0", ready); end
        idle(TB_TO - 1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL coll_reload got %b want 0", frame_err); end
        idle(1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL coll_expire got %b want 1", frame_err); end
        idle(1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL coll_pulse_len got %b want 0", frame_err); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL coll_hunt got %b want 1", ready); end
    endtask

    task automatic test_reset_mid_recv;
        send_byte(SYNC_BYTE);
        for (int i = 0; i < 400; i++) send_byte(8'hEE);
        rst_n = 1'b0;
        idle(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b want 1", ready); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL midrst_start got %b want 0", start); end
        rst_n = 1'b1;
        chk_sum = 8'h00;
        send_byte(SYNC_BYTE);
        send_pixels(1, 0, N_PIX);
`ifdef IMG_LOADER_CHKSUM_EN
        checks++; if (chk_sum !== 8'h58) begin errors++; $display("[TB] FAIL midrst_bench_sum got %0h want 58", chk_sum); end
        send_byte(8'h58);
`endif
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL midrst_start2 got %b want 1", start); end
        read_pix(10'd0);
        checks++; if (rd_data !== 8'd7) begin errors++; $display("[TB] FAIL midrst_buf0 got %0d want 7", rd_data); end
        read_pix(10'd399);
        checks++; if (rd_data !== 8'd180) begin errors++; $display("[TB] FAIL midrst_buf399 got %0d want 180", rd_data); end
        read_pix(10'd400);
        checks++; if (rd_data !== 8'd183) begin errors++; $display("[TB] FAIL midrst_buf400 got %0d want 183", rd_data); end
        read_pix(10'd783);
        checks++; if (rd_data !== 8'd52) begin errors++; $display("[TB] FAIL midrst_buf783 got %0d want 52", rd_data); end
        done = 1'b1;
        idle(1);
        done = 1'b0;
        idle(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_back_hunt got %b want 1", ready); end
    endtask

`ifdef IMG_LOADER_CHKSUM_EN
    task automatic test_checksum;
        chk_sum = 8'h00;
        send_byte(SYNC_BYTE);
        send_pixels(0, 0, N_PIX);
        send_byte(8'hF9);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL chk_bad_err got %b want 1", frame_err); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL chk_bad_start got %b want 0", start); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL chk_bad_hunt got %b want 1", ready); end
        idle(1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL chk_bad_pulse got %b want 0", frame_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_frame();
        test_overrun();
        test_handshake();
        test_timeout();
        test_timeout_collision();
        test_reset_mid_recv();
`ifdef IMG_LOADER_CHKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
